// File: rtl/strobe_sequencer_pkg.sv
// strobe_sequencer_pkg: shared state encoding and interval clamp floor for the strobe sequencer.
package strobe_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  localparam int CLAMP_MIN = 2;
endpackage

// File: rtl/strobe_sequencer_if.sv
// strobe_sequencer_if: control, table-write and status signals of the strobe sequencer.
interface strobe_sequencer_if #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  logic tick;
  logic start;
  logic stop;
  logic loop;
  logic [AW-1:0] last_idx;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic busy;
  logic step_strobe;
  logic [AW-1:0] step_idx;
  logic done;
  logic tick_overrun;
  modport slave (
    input tick, start, stop, loop, last_idx, wr_en, wr_addr, wr_data,
    output busy, step_strobe, step_idx, done, tick_overrun
  );
  modport master (
    output tick, start, stop, loop, last_idx, wr_en, wr_addr, wr_data,
    input busy, step_strobe, step_idx, done, tick_overrun
  );
endinterface

// File: rtl/strobe_sequencer_counter.sv
// counter_with_strobe: counts enables and strobes one cycle after the reset_value-th enable.
// The count update is pipelined LATENCY stages, so enables must be spaced by LATENCY idle cycles.
module counter_with_strobe #(
  parameter int WIDTH = 25,
  parameter int LATENCY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_reset_value,
  output logic             o_strobe
);
  logic [WIDTH-1:0] r_count;
  logic w_hit;
  logic w_upd;
  logic w_wrap;
  assign w_hit = i_enable && (r_count + WIDTH'(1) == i_reset_value);
  if (LATENCY == 0) begin : g_direct
    assign w_upd = i_enable;
    assign w_wrap = w_hit;
  end else begin : g_pipe
    logic [LATENCY-1:0] r_en_d;
    logic [LATENCY-1:0] r_hit_d;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_en_d <= '0;
        r_hit_d <= '0;
      end else begin
        r_en_d <= LATENCY'({r_en_d, i_enable});
        r_hit_d <= LATENCY'({r_hit_d, w_hit});
      end
    end
    assign w_upd = r_en_d[LATENCY-1];
    assign w_wrap = r_hit_d[LATENCY-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      o_strobe <= 1'b0;
    end else begin
      o_strobe <= w_hit;
      r_count <= w_wrap ? '0 : w_upd ? r_count + WIDTH'(1) : r_count;
    end
  end
endmodule

// File: rtl/strobe_sequencer.sv
// strobe_sequencer: walks a table of tick intervals on one shared counter, strobing at each boundary.
module strobe_sequencer #(
  parameter int WIDTH = 25,
  parameter int LATENCY = 0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  strobe_sequencer_if.slave sif
);
  import strobe_sequencer_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LATENCY + 2);
  state_t r_state;
  state_t w_next;
  logic [WIDTH-1:0] r_table [DEPTH];
  logic [WIDTH-1:0] r_cur_rv;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_last;
  logic [AW-1:0] w_nidx;
  logic [LW-1:0] r_low;
  logic r_loop, r_pending, r_overrun, r_en_prev, r_clr_prev;
  logic w_strobe, w_clr, w_run, w_can, w_enable, w_step, w_end, w_done, w_start;
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    return (v < WIDTH'(CLAMP_MIN)) ? WIDTH'(CLAMP_MIN) : v;
  endfunction
  always_comb begin
    w_start = sif.start && !sif.stop && r_state == IDLE;
    w_clr = r_state == ARM || sif.stop;
    w_run = r_state == RUN && !sif.stop;
    w_can = w_run && !r_en_prev && !r_clr_prev && !w_strobe && r_low >= LW'(LATENCY);
    w_enable = w_can && (r_pending || sif.tick);
    w_step = r_state == RUN && w_strobe;
    w_end = r_idx == r_last;
    w_nidx = w_end ? '0 : r_idx + AW'(1);
    w_done = w_step && w_end && !r_loop && !sif.stop;
    w_next = sif.stop ? IDLE : r_state == IDLE ? (sif.start ? ARM : IDLE) : r_state == ARM ? RUN : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (sif.wr_en) r_table[sif.wr_addr] <= sif.wr_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_last <= '0;
      r_loop <= 1'b0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_en_prev <= 1'b0;
      r_clr_prev <= 1'b0;
      r_low <= '0;
      r_cur_rv <= WIDTH'(CLAMP_MIN);
    end else begin
      r_state <= w_next;
      r_en_prev <= w_enable;
      r_clr_prev <= w_clr;
      r_low <= w_enable ? '0 : w_clr ? LW'(LATENCY) : r_low >= LW'(LATENCY) ? r_low : r_low + LW'(1);
      // a pending issue hands the pending slot to a same-cycle tick
      r_pending <= w_run && (w_can ? r_pending && sif.tick : sif.tick || r_pending);
      r_overrun <= w_start ? 1'b0 : r_overrun || (w_run && sif.tick && r_pending && !w_can);
      r_idx <= w_start ? '0 : (w_step && !w_done) ? w_nidx : r_idx;
      if (w_start) begin
        r_loop <= sif.loop;
        r_last <= sif.last_idx;
      end
      if (r_state == ARM) r_cur_rv <= clamp(r_table[0]);
      else if (w_step && !w_done) r_cur_rv <= clamp(r_table[w_nidx]);
    end
  end
  counter_with_strobe #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_counter (
    .clk(clk),
    .rst(rst || w_clr),
    .i_enable(w_enable),
    .i_reset_value(r_cur_rv),
    .o_strobe(w_strobe)
  );
  assign sif.busy = r_state != IDLE;
  assign sif.step_strobe = w_step;
  assign sif.step_idx = r_idx;
  assign sif.done = w_done;
  assign sif.tick_overrun = r_overrun;
endmodule
